// File: rtl/music_player_if.sv
// Handshake and ROM bus between the button logic, the song ROM and
// music_player. The player sits on the slave side.
interface music_player_if;
    logic       play;
    logic       stop;
    logic [7:0] adrs;
    logic [5:0] note;
    logic       speaker;
    logic       busy;
    logic       done;

    modport master (
        output play,
        output stop,
        output note,
        input  adrs,
        input  speaker,
        input  busy,
        input  done
    );

    modport slave (
        input  play,
        input  stop,
        input  note,
        output adrs,
        output speaker,
        output busy,
        output done
    );
endinterface

// File: rtl/music_player.sv
// Song ROM sequencer and square-wave tone generator.
// Define MUSIC_PLAYER_LOOP_EN to loop the song until stop.
module music_player #(
    parameter int BEAT_DIV  = 12_500_000,
    parameter int LAST_ADRS = 242
) (
    input  logic          clk,
    input  logic          rst_n,
    music_player_if.slave bus
);

    localparam int SW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(BEAT_DIV - 1);
    localparam logic [7:0]    ADRS_LAST = 8'(LAST_ADRS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY
    } state_t;

    state_t        state;
    logic [SW-1:0] step_cnt;
    logic [5:0]    cur_note;
    logic [19:0]   tone_cnt;
    logic [7:0]    adrs_q;
    logic          speaker_q;
    logic          busy_q;
    logic          done_q;

    logic [2:0]    oct;
    logic [3:0]    semi;
    logic [19:0]   base;
    logic [19:0]   half_per;
    logic          tone_wrap;

    assign bus.adrs    = adrs_q;
    assign bus.speaker = speaker_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Split the note code into octave and semitone without a divider.
    always_comb begin
        oct  = 3'd0;
        semi = 4'(cur_note);
        unique case (1'b1)
            (cur_note >= 6'd60): begin
                oct  = 3'd5;
                semi = 4'(cur_note - 6'd60);
            end
            (cur_note >= 6'd48) && (cur_note < 6'd60): begin
                oct  = 3'd4;
                semi = 4'(cur_note - 6'd48);
            end
            (cur_note >= 6'd36) && (cur_note < 6'd48): begin
                oct  = 3'd3;
                semi = 4'(cur_note - 6'd36);
            end
            (cur_note >= 6'd24) && (cur_note < 6'd36): begin
                oct  = 3'd2;
                semi = 4'(cur_note - 6'd24);
            end
            (cur_note >= 6'd12) && (cur_note < 6'd24): begin
                oct  = 3'd1;
                semi = 4'(cur_note - 6'd12);
            end
            (cur_note < 6'd12): begin
                oct  = 3'd0;
                semi = 4'(cur_note);
            end
            default: begin
                oct  = 3'd0;
                semi = 4'd0;
            end
        endcase
    end

    // Octave-0 half-periods (C2 upward) in clk cycles.
    always_comb begin
        base = 20'd764468;
        case (semi)
            4'd0:    base = 20'd764468;
            4'd1:    base = 20'd721542;
            4'd2:    base = 20'd681050;
            4'd3:    base = 20'd642821;
            4'd4:    base = 20'd606748;
            4'd5:    base = 20'd572704;
            4'd6:    base = 20'd540567;
            4'd7:    base = 20'd510221;
            4'd8:    base = 20'd481579;
            4'd9:    base = 20'd454545;
            4'd10:   base = 20'd429033;
            4'd11:   base = 20'd404956;
            default: base = 20'd764468;
        endcase
    end

    assign half_per  = base >> oct;
    assign tone_wrap = (tone_cnt == half_per - 20'd1);

    // Sequencer FSM with the tone counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_cnt  <= '0;
            cur_note  <= 6'd0;
            tone_cnt  <= 20'd0;
            adrs_q    <= 8'd0;
            speaker_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (cur_note == 6'd0) begin
                tone_cnt  <= 20'd0;
                speaker_q <= 1'b0;
            end else if (tone_wrap) begin
                tone_cnt  <= 20'd0;
                speaker_q <= ~speaker_q;
            end else begin
                tone_cnt <= tone_cnt + 20'd1;
            end

            if (state != IDLE) begin
                step_cnt <= step_cnt + 1'b1;
            end

            if ((state != IDLE) && bus.stop) begin
                state     <= IDLE;
                step_cnt  <= '0;
                cur_note  <= 6'd0;
                tone_cnt  <= 20'd0;
                speaker_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.play && !bus.stop) begin
                            state     <= FETCH;
                            adrs_q    <= 8'd0;
                            busy_q    <= 1'b1;
                            step_cnt  <= '0;
                            cur_note  <= 6'd0;
                            tone_cnt  <= 20'd0;
                            speaker_q <= 1'b0;
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        state    <= PLAY;
                        cur_note <= bus.note;
                        if (bus.note != cur_note) begin
                            tone_cnt  <= 20'd0;
                            speaker_q <= 1'b0;
                        end
                    end
                    PLAY: begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            if (adrs_q != ADRS_LAST) begin
                                adrs_q <= adrs_q + 8'd1;
                                state  <= FETCH;
                            end else begin
                                done_q <= 1'b1;
`ifdef MUSIC_PLAYER_LOOP_EN
                                adrs_q <= 8'd0;
                                state  <= FETCH;
`else
                                state     <= IDLE;
                                busy_q    <= 1'b0;
                                cur_note  <= 6'd0;
                                tone_cnt  <= 20'd0;
                                speaker_q <= 1'b0;
`endif
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player: timing, tones, rest, stop, reset.
// Three instances share one clock with different beat rates and ROMs.
module tb_music_player;

`ifdef MUSIC_PLAYER_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   a_done  = 0;
    int   b_done  = 0;
    int   c_done  = 0;
    int   c_rest_hi = 0;
    logic c_win = 1'b0;
    int   t0;
    int   n0;

    music_player_if ia ();
    music_player_if ib ();
    music_player_if ic ();

    music_player #(.BEAT_DIV(64), .LAST_ADRS(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    music_player #(.BEAT_DIV(30000), .LAST_ADRS(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    music_player #(.BEAT_DIV(24000), .LAST_ADRS(1)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ic)
    );

    always #5 clk = ~clk;

    // Edge counter used to place every step and check.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] rom_a(input logic [7:0] a);
        case (a)
            8'd0:    return 6'd57;
            8'd1:    return 6'd57;
            8'd2:    return 6'd0;
            8'd3:    return 6'd9;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] rom_c(input logic [7:0] a);
        case (a)
            8'd0:    return 6'd63;
            default: return 6'd0;
        endcase
    endfunction

    // Behavioural registered song ROMs.
    always @(posedge clk) begin
        ia.note <= rom_a(ia.adrs);
        ib.note <= (ib.adrs < 8'd2) ? 6'd57 : 6'd0;
        ic.note <= rom_c(ic.adrs);
    end

    // Count done pulses and speaker highs inside the rest window.
    always @(negedge clk) begin
        if (ia.done) a_done <= a_done + 1;
        if (ib.done) b_done <= b_done + 1;
        if (ic.done) c_done <= c_done + 1;
        if (c_win && ic.speaker) c_rest_hi <= c_rest_hi + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        ia.play = 1'b0; ia.stop = 1'b0;
        ib.play = 1'b0; ib.stop = 1'b0;
        ic.play = 1'b0; ic.stop = 1'b0;

        step(3);
        chk("rst_adrs", 32'(ia.adrs), 0);
        chk("rst_speaker", 32'(ia.speaker), 0);
        chk("rst_busy", 32'(ia.busy), 0);
        chk("rst_done", 32'(ia.done), 0);
        chk("rst_busy_b", 32'(ib.busy), 0);
        chk("rst_busy_c", 32'(ic.busy), 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_busy", 32'(ia.busy), 0);

        ia.play = 1'b1; step(1); ia.play = 1'b0;
        t0 = cyc;
        chk("a_start_adrs", 32'(ia.adrs), 0);
        chk("a_start_busy", 32'(ia.busy), 1);
        wait_until(t0 + 63);
        chk("a_adrs0_hold", 32'(ia.adrs), 0);
        wait_until(t0 + 64);
        chk("a_adrs1", 32'(ia.adrs), 1);
        ia.play = 1'b1; step(1); ia.play = 1'b0;
        wait_until(t0 + 127);
        chk("a_play_ignored", 32'(ia.adrs), 1);
        wait_until(t0 + 128);
        chk("a_adrs2", 32'(ia.adrs), 2);
        wait_until(t0 + 192);
        chk("a_adrs3", 32'(ia.adrs), 3);
        wait_until(t0 + 255);
        chk("a_busy_255", 32'(ia.busy), 1);
        chk("a_nodone_255", 32'(a_done), 0);
        wait_until(t0 + 256);
        chk("a_done_256", 32'(ia.done), 1);
        chk("a_busy_256", 32'(ia.busy), 32'(LOOP));
        chk("a_adrs_256", 32'(ia.adrs), LOOP ? 0 : 3);
        step(1);
        chk("a_done_pulse", 32'(ia.done), 0);
        chk("a_done_count", 32'(a_done), 1);
`ifdef MUSIC_PLAYER_LOOP_EN
        wait_until(t0 + 511);
        chk("loop_busy_511", 32'(ia.busy), 1);
        chk("loop_adrs_511", 32'(ia.adrs), 3);
        wait_until(t0 + 512);
        chk("loop_done_512", 32'(ia.done), 1);
        chk("loop_adrs_512", 32'(ia.adrs), 0);
        chk("loop_busy_512", 32'(ia.busy), 1);
`endif
        ia.stop = 1'b1; step(1); ia.stop = 1'b0;
        step(2);
        chk("a_idle_after", 32'(ia.busy), 0);

        ia.play = 1'b1; step(1); ia.play = 1'b0;
        t0 = cyc;
        n0 = a_done;
        wait_until(t0 + 138);
        chk("stop_pre_adrs", 32'(ia.adrs), 2);
        ia.stop = 1'b1; step(1); ia.stop = 1'b0;
        chk("stop_busy", 32'(ia.busy), 0);
        chk("stop_speaker", 32'(ia.speaker), 0);
        chk("stop_adrs_hold", 32'(ia.adrs), 2);
        chk("stop_done", 32'(ia.done), 0);
        wait_until(t0 + 300);
        chk("stop_no_done", 32'(a_done - n0), 0);
        chk("stop_still_idle", 32'(ia.busy), 0);

        ia.play = 1'b1; ia.stop = 1'b1;
        step(1);
        ia.play = 1'b0; ia.stop = 1'b0;
        chk("playstop_busy", 32'(ia.busy), 0);
        chk("playstop_adrs", 32'(ia.adrs), 2);
        step(3);
        chk("playstop_busy2", 32'(ia.busy), 0);

        ia.play = 1'b1; step(1); ia.play = 1'b0;
        t0 = cyc;
        wait_until(t0 + 70);
        chk("rmid_adrs", 32'(ia.adrs), 1);
        chk("rmid_busy", 32'(ia.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rmid_adrs0", 32'(ia.adrs), 0);
        chk("rmid_busy0", 32'(ia.busy), 0);
        chk("rmid_speaker0", 32'(ia.speaker), 0);
        chk("rmid_done0", 32'(ia.done), 0);
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("rmid_idle_busy", 32'(ia.busy), 0);
        chk("rmid_idle_adrs", 32'(ia.adrs), 0);

        ib.play = 1'b1; ic.play = 1'b1;
        step(1);
        ib.play = 1'b0; ic.play = 1'b0;
        t0 = cyc;
        wait_until(t0 + 2);
        chk("b_spk_load", 32'(ib.speaker), 0);
        chk("c_spk_load", 32'(ic.speaker), 0);
        wait_until(t0 + 20089);
        chk("c_max_pre", 32'(ic.speaker), 0);
        wait_until(t0 + 20090);
        chk("c_max_toggle", 32'(ic.speaker), 1);
        wait_until(t0 + 24001);
        chk("c_fetch_sound", 32'(ic.speaker), 1);
        chk("c_adrs1", 32'(ic.adrs), 1);
        wait_until(t0 + 24002);
        chk("c_rest_load", 32'(ic.speaker), 0);
        c_win = 1'b1;
        wait_until(t0 + 28410);
        chk("b_tone_pre", 32'(ib.speaker), 0);
        wait_until(t0 + 28411);
        chk("b_tone_half", 32'(ib.speaker), 1);
        wait_until(t0 + 30000);
        chk("b_adrs1", 32'(ib.adrs), 1);
        wait_until(t0 + 30002);
        chk("b_same_note", 32'(ib.speaker), 1);
        wait_until(t0 + 40178);
        chk("c_rest_mid", 32'(ic.speaker), 0);
        wait_until(t0 + 47999);
        c_win = 1'b0;
        chk("c_rest_window", 32'(c_rest_hi), 0);
        chk("c_busy_end", 32'(ic.busy), 1);
        wait_until(t0 + 48000);
        chk("c_done", 32'(ic.done), 1);
        chk("c_busy_done", 32'(ic.busy), 32'(LOOP));
        wait_until(t0 + 56819);
        chk("b_period_pre", 32'(ib.speaker), 1);
        wait_until(t0 + 56820);
        chk("b_period_full", 32'(ib.speaker), 0);

        ib.stop = 1'b1; ic.stop = 1'b1;
        step(1);
        ib.stop = 1'b0; ic.stop = 1'b0;
        chk("b_stop_busy", 32'(ib.busy), 0);
        chk("b_stop_speaker", 32'(ib.speaker), 0);
        chk("b_stop_adrs", 32'(ib.adrs), 1);
        step(2);
        chk("b_no_done", 32'(b_done), 0);
        chk("c_done_count", 32'(c_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
